// File: rtl/spi_pkg.sv
// Shared types for the SPI arbiter: FSM state encoding and the round-robin pick.
package spi_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_RESP} state_t;

    localparam int RR_MAX = 8;

    // Returns {valid, index}: first set bit of req at or after ptr, wrapping at n.
    function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] req,
                                           input logic [3:0]        n,
                                           input logic [2:0]        ptr);
        logic [3:0] sum;
        rr_pick = 4'd0;
        for (int k = RR_MAX - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + 4'(k);
            if (sum >= n) sum = sum - n;
            // Walk downward so the smallest distance from ptr overwrites last.
            if ((4'(k) < n) && req[sum[2:0]]) rr_pick = {1'b1, sum[2:0]};
        end
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin winner selection over NUM_REQ requesters starting at ptr.
module rr_select
    import spi_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    logic [RR_MAX-1:0] w_req;
    logic [2:0]        w_ptr;
    logic [3:0]        w_pick;

    always_comb begin
        w_req              = '0;
        w_req[NUM_REQ-1:0] = req;
        w_ptr              = 3'(ptr);
        w_pick             = rr_pick(w_req, 4'(NUM_REQ), w_ptr);
    end

    assign valid = w_pick[3];
    assign index = IDX_W'(w_pick[2:0]);

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master between NUM_REQ requesters: round-robin grant,
// one transfer at a time, with a WAIT-state timeout that reports err.
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          err,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          spi_start,
    output logic [DATA_WIDTH-1:0]         spi_tx_data,
    input  logic                          spi_done,
    input  logic [DATA_WIDTH-1:0]         spi_rx_data
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                r_state, w_next;
    logic [IDX_W-1:0]      r_ptr, r_win, w_idx;
    logic                  w_valid, w_timeout;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_tx, r_rsp, w_sel_data;
    logic [NUM_REQ-1:0]    r_grant;
    logic                  r_err;

    rr_select #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_valid),
        .index (w_idx)
    );

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (w_idx == IDX_W'(i)) w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_valid) w_next = ST_START;
            ST_START: w_next = ST_WAIT;
            ST_WAIT: begin
                // A done arriving on the last timeout cycle still wins.
                if (spi_done) begin
                    w_next = ST_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_next    = ST_RESP;
                    w_timeout = 1'b1;
                end
            end
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_win   <= '0;
            r_cnt   <= '0;
            r_tx    <= '0;
            r_rsp   <= '0;
            r_grant <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_valid) begin
                    r_win   <= w_idx;
                    r_tx    <= w_sel_data;
                    r_grant <= NUM_REQ'(1) << w_idx;
                end
                ST_START: begin
                    r_cnt <= '0;
                    r_err <= 1'b0;
                end
                ST_WAIT: begin
                    if (spi_done)       r_rsp <= spi_rx_data;
                    else if (w_timeout) r_err <= 1'b1;
                    else                r_cnt <= r_cnt + CNT_W'(1);
                end
                ST_RESP: begin
                    r_grant <= '0;
                    r_ptr   <= (r_win == IDX_W'(NUM_REQ - 1)) ? '0 : r_win + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign ack         = (r_state == ST_RESP) ? r_grant : '0;
    assign err         = (r_state == ST_RESP) & r_err;
    assign rsp_data    = r_rsp;
    assign grant       = r_grant;
    assign spi_start   = (r_state == ST_START);
    assign spi_tx_data = r_tx;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: vector table of single transfers plus
// hand sequences for contention, reset mid-WAIT, timeout and the done/timeout race.
module tb_spi_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam logic [NR*DW-1:0] D0 = 64'h4444_3333_A55A_1111;
    localparam logic [NR*DW-1:0] D1 = 64'hDEAD_BEEF_0123_4567;

    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0]    req, req16, ack, ack16, grant, grant16;
    logic [NR*DW-1:0] req_data, req_data16;
    logic             err, err16, spi_start, spi_start16, spi_done, spi_done16;
    logic [DW-1:0]    rsp, rsp16, tx, tx16, spi_rx, spi_rx16;

    int total = 0;
    int bad   = 0;

    spi_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack), .err(err), .rsp_data(rsp), .grant(grant),
        .spi_start(spi_start), .spi_tx_data(tx),
        .spi_done(spi_done), .spi_rx_data(spi_rx)
    );

    spi_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) u_dut16 (
        .clk(clk), .rst(rst), .req(req16), .req_data(req_data16),
        .ack(ack16), .err(err16), .rsp_data(rsp16), .grant(grant16),
        .spi_start(spi_start16), .spi_tx_data(tx16),
        .spi_done(spi_done16), .spi_rx_data(spi_rx16)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [NR-1:0]    req;
        logic [NR*DW-1:0] data;
        logic [DW-1:0]    rx;
        int               delay;
        logic             drop;
        logic [NR-1:0]    exp_grant;
        logic [DW-1:0]    exp_tx;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic xfer(input vec_t v, input string nm);
        logic ok_hold;
        req      = v.req;
        req_data = v.data;
        tick();
        chk({nm, "_start"}, 64'(spi_start), 64'd1);
        if (spi_start !== 1'b1) begin
            req = '0;
            repeat (40) tick();
            return;
        end
        chk({nm, "_tx"}, 64'(tx), 64'(v.exp_tx));
        chk({nm, "_grant"}, 64'(grant), 64'(v.exp_grant));
        tick();
        chk({nm, "_start_once"}, 64'(spi_start), 64'd0);
        req_data = ~v.data;
        if (v.drop) req = '0;
        ok_hold = 1'b1;
        for (int i = 0; i < v.delay; i++) begin
            if (grant !== v.exp_grant || ack !== '0 || spi_start !== 1'b0) ok_hold = 1'b0;
            tick();
        end
        chk({nm, "_hold"}, 64'(ok_hold), 64'd1);
        spi_done = 1'b1;
        spi_rx   = v.rx;
        tick();
        spi_done = 1'b0;
        spi_rx   = '0;
        chk({nm, "_ack"}, 64'(ack), 64'(v.exp_grant));
        chk({nm, "_err"}, 64'(err), 64'd0);
        chk({nm, "_rsp"}, 64'(rsp), 64'(v.rx));
        chk({nm, "_tx_stable"}, 64'(tx), 64'(v.exp_tx));
        req      = '0;
        req_data = '0;
        tick();
        chk({nm, "_idle"}, 64'({ack, grant}), 64'd0);
    endtask

    initial begin
        int   nack, pend, cyc, k;
        logic multi, quiet, ok;
        int   order[5];
        int   exp_order[5];

        rst = 1'b1; req = '0; req_data = '0; spi_done = 1'b0; spi_rx = '0;
        req16 = '0; req_data16 = '0; spi_done16 = 1'b0; spi_rx16 = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_start", 64'(spi_start), 64'd0);
        chk("rst_tx", 64'(tx), 64'd0);
        chk("rst_rsp", 64'(rsp), 64'd0);

        // ptr sequence after each vector: 2,3,0,1,1,3,2,3
        vecs[0] = '{4'b0010, D0, 16'h1234, 300, 1'b0, 4'b0010, 16'hA55A};
        vecs[1] = '{4'b0101, D0, 16'h0F0F, 2,   1'b0, 4'b0100, 16'h3333};
        vecs[2] = '{4'b1001, D1, 16'h5A5A, 5,   1'b0, 4'b1000, 16'hDEAD};
        vecs[3] = '{4'b1001, D1, 16'h6B6B, 1,   1'b0, 4'b0001, 16'h4567};
        vecs[4] = '{4'b0001, D1, 16'h7C7C, 0,   1'b0, 4'b0001, 16'h4567};
        vecs[5] = '{4'b1100, D0, 16'h8D8D, 4,   1'b1, 4'b0100, 16'h3333};
        vecs[6] = '{4'b0110, D0, 16'h9E9E, 3,   1'b0, 4'b0010, 16'hA55A};
        vecs[7] = '{4'b1111, D0, 16'hFFFF, 1,   1'b0, 4'b0100, 16'h3333};
        for (int i = 0; i < 8; i++) xfer(vecs[i], $sformatf("vec%0d", i));

        // Contention: all four requesting from reset, SPI answers two cycles into WAIT.
        exp_order = '{0, 1, 2, 3, 0};
        order     = '{7, 7, 7, 7, 7};
        rst = 1'b1; req = 4'b1111; req_data = D0;
        tick();
        rst = 1'b0;
        nack = 0; pend = 0; cyc = 0; multi = 1'b0;
        while (nack < 5 && cyc < 300) begin
            tick();
            cyc++;
            spi_done = 1'b0;
            if ($countones(grant) > 1) multi = 1'b1;
            if (ack != '0) begin
                for (int b = 0; b < NR; b++) if (ack[b]) order[nack] = b;
                nack++;
            end
            if (spi_start) pend = 2;
            else if (pend > 0) begin
                pend--;
                if (pend == 0) spi_done = 1'b1;
            end
        end
        req = '0; spi_done = 1'b0;
        chk("cont_nack", 64'(nack), 64'd5);
        chk("cont_multihot", 64'(multi), 64'd0);
        for (int i = 0; i < 5; i++) chk($sformatf("cont_order%0d", i), 64'(order[i]), 64'(exp_order[i]));
        repeat (3) tick();

        // Reset in WAIT: transfer abandoned, late done ignored, ptr back to 0.
        req = 4'b0100; req_data = D0;
        tick();
        chk("rw_start", 64'(spi_start), 64'd1);
        repeat (2) tick();
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0;
        chk("rw_after_rst", 64'({grant, spi_start}), 64'd0);
        repeat (4) tick();
        spi_done = 1'b1; spi_rx = 16'h7777;
        tick();
        spi_done = 1'b0;
        quiet = 1'b1;
        repeat (8) begin
            if (ack != '0 || spi_start || grant != '0) quiet = 1'b0;
            tick();
        end
        chk("rw_quiet", 64'(quiet), 64'd1);
        chk("rw_rsp", 64'(rsp), 64'd0);
        req = 4'b1111;
        tick();
        chk("rw_ptr0", 64'(grant), 64'b0001);
        tick();
        spi_done = 1'b1; spi_rx = 16'h0001;
        tick();
        spi_done = 1'b0; req = '0;
        tick();

        // TIMEOUT_CYCLES=16 instance: one good transfer to load rsp_data.
        req16 = 4'b0010; req_data16 = 64'h0000_0000_1357_0000;
        ok = 1'b0;
        for (int n = 0; n < 4 && !ok; n++) begin tick(); ok = spi_start16; end
        chk("t16_start", 64'(ok), 64'd1);
        chk("t16_tx", 64'(tx16), 64'h1357);
        repeat (2) tick();
        spi_done16 = 1'b1; spi_rx16 = 16'hBEEF;
        tick();
        spi_done16 = 1'b0;
        chk("t16_ack", 64'(ack16), 64'b0010);
        chk("t16_rsp", 64'(rsp16), 64'hBEEF);
        req16 = '0;
        tick();

        // Timeout: no done at all.
        req16 = 4'b0100;
        ok = 1'b0;
        for (int n = 0; n < 4 && !ok; n++) begin tick(); ok = spi_start16; end
        chk("to_start", 64'(ok), 64'd1);
        tick();
        k = 0;
        while (ack16 == '0 && k < 40) begin tick(); k++; end
        chk("to_cycles", 64'(k), 64'd16);
        chk("to_ack", 64'(ack16), 64'b0100);
        chk("to_err", 64'(err16), 64'd1);
        chk("to_rsp_kept", 64'(rsp16), 64'hBEEF);
        req16 = '0;
        tick();
        chk("to_err_pulse", 64'({err16, ack16}), 64'd0);

        // Race: done on the final timeout cycle is a success.
        req16 = 4'b0001;
        ok = 1'b0;
        for (int n = 0; n < 4 && !ok; n++) begin tick(); ok = spi_start16; end
        chk("race_start", 64'(ok), 64'd1);
        tick();
        repeat (15) tick();
        spi_done16 = 1'b1; spi_rx16 = 16'hCAFE;
        tick();
        spi_done16 = 1'b0;
        chk("race_ack", 64'(ack16), 64'b0001);
        chk("race_err", 64'(err16), 64'd0);
        chk("race_rsp", 64'(rsp16), 64'hCAFE);
        req16 = '0;
        tick();

        // done while IDLE must not ack or capture.
        spi_done16 = 1'b1; spi_rx16 = 16'h1111;
        tick();
        spi_done16 = 1'b0;
        tick();
        chk("idle_done_ack", 64'(ack16), 64'd0);
        chk("idle_done_rsp", 64'(rsp16), 64'hCAFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
